// File: rtl/dmem_port_ctrl_pkg.sv
// Shared types and constants for the dataMemory port controller.
// FSM encoding, requester source codes and the round-robin pick rule.
package dmem_port_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MISS = 2'd1,
      S_ACC  = 2'd2,
      S_RESP = 2'd3
   } state_e;

   localparam logic SRC_LSU = 1'b0;
   localparam logic SRC_LSQ = 1'b1;

   localparam int DEF_MISS_LATENCY = 4;

   // On a conflict the side that did not win last time gets the port.
   function automatic logic rr_pick(input logic lsu_v, input logic lsq_v, input logic rr_last);
      if (lsu_v && lsq_v) return ~rr_last;
      if (lsq_v)          return SRC_LSQ;
      return SRC_LSU;
   endfunction

endpackage

// File: rtl/dmem_port_ctrl_if.sv
// Request, dataMemory and response bundle between LSU/LSQ, the port controller and dataMemory.
// slave = controller view, master = environment (requesters + memory) view.
interface dmem_port_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_pc;
   logic [ADDR_W-1:0] lsu_addr;

   logic              lsq_req_valid;
   logic              lsq_req_ready;
   logic [ADDR_W-1:0] lsq_pc;
   logic [ADDR_W-1:0] lsq_addr;
   logic [DATA_W-1:0] lsq_wdata;
   logic              lsq_is_store;
   logic              lsq_store_size;

   logic              cache_miss;

   logic [ADDR_W-1:0] mem_pc;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic              mem_store_size;
   logic              mem_from_lsq;
   logic              mem_cache_miss;
   logic [DATA_W-1:0] mem_rdata;

   logic              resp_valid;
   logic [ADDR_W-1:0] resp_pc;
   logic [DATA_W-1:0] resp_data;
   logic              resp_to_lsq;
   logic              busy;

   modport slave (
      input  lsu_req_valid, lsu_pc, lsu_addr,
      input  lsq_req_valid, lsq_pc, lsq_addr, lsq_wdata, lsq_is_store, lsq_store_size,
      input  cache_miss, mem_rdata,
      output lsu_req_ready, lsq_req_ready,
      output mem_pc, mem_addr, mem_wdata, mem_read, mem_write,
      output mem_store_size, mem_from_lsq, mem_cache_miss,
      output resp_valid, resp_pc, resp_data, resp_to_lsq, busy
   );

   modport master (
      output lsu_req_valid, lsu_pc, lsu_addr,
      output lsq_req_valid, lsq_pc, lsq_addr, lsq_wdata, lsq_is_store, lsq_store_size,
      output cache_miss, mem_rdata,
      input  lsu_req_ready, lsq_req_ready,
      input  mem_pc, mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_store_size, mem_from_lsq, mem_cache_miss,
      input  resp_valid, resp_pc, resp_data, resp_to_lsq, busy
   );

endinterface

// File: rtl/dmem_port_ctrl_miss_timer.sv
// Loadable down-counter that models the cache-miss penalty.
// zero is raised once the loaded count has been consumed.
module dmem_miss_timer #(
   parameter int CNT_W = 3
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_port_ctrl.sv
// Arbitrates the single dataMemory port between LSU loads and LSQ ops, inserts the miss
// penalty, issues one access cycle and returns a PC-tagged completion pulse.
module dmem_port_ctrl
   import dmem_port_ctrl_pkg::*;
#(
   parameter int MISS_LATENCY = DEF_MISS_LATENCY,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
)(
   input logic             clk,
   input logic             rstn,
   dmem_port_ctrl_if.slave bus
);

   localparam int               CNT_W     = $clog2(MISS_LATENCY + 1);
   localparam logic [CNT_W-1:0] MISS_INIT = CNT_W'(MISS_LATENCY - 1);

   state_e            state_q, state_d;
   logic              rr_last_q, rr_last_d;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              is_store_q, is_store_d;
   logic              size_q, size_d;
   logic              src_q, src_d;
   logic              miss_q, miss_d;

   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;

   logic              resp_valid_q, resp_valid_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_to_lsq_q, resp_to_lsq_d;

   logic              grant_src;
   logic              lsu_rdy, lsq_rdy, hs;
   logic              new_is_store;
   logic              tmr_load, tmr_dec, tmr_zero;

   dmem_miss_timer #(.CNT_W(CNT_W)) u_miss_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tmr_load),
      .load_val (MISS_INIT),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Grants are combinational but only ever offered from IDLE, so at most one side sees ready.
   always_comb begin
      grant_src    = rr_pick(bus.lsu_req_valid, bus.lsq_req_valid, rr_last_q);
      lsu_rdy      = (state_q == S_IDLE) && bus.lsu_req_valid && (grant_src == SRC_LSU);
      lsq_rdy      = (state_q == S_IDLE) && bus.lsq_req_valid && (grant_src == SRC_LSQ);
      hs           = lsu_rdy || lsq_rdy;
      new_is_store = lsq_rdy && bus.lsq_is_store;
   end

   always_comb begin
      state_d       = state_q;
      rr_last_d     = rr_last_q;
      pc_d          = pc_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      is_store_d    = is_store_q;
      size_d        = size_q;
      src_d         = src_q;
      miss_d        = miss_q;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      resp_valid_d  = 1'b0;
      resp_pc_d     = resp_pc_q;
      resp_data_d   = resp_data_q;
      resp_to_lsq_d = resp_to_lsq_q;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hs) begin
               rr_last_d  = lsq_rdy ? SRC_LSQ : SRC_LSU;
               src_d      = lsq_rdy ? SRC_LSQ : SRC_LSU;
               pc_d       = lsq_rdy ? bus.lsq_pc   : bus.lsu_pc;
               addr_d     = lsq_rdy ? bus.lsq_addr : bus.lsu_addr;
               wdata_d    = lsq_rdy ? bus.lsq_wdata : '0;
               size_d     = lsq_rdy && bus.lsq_store_size;
               is_store_d = new_is_store;
               miss_d     = bus.cache_miss;
               if (bus.cache_miss) begin
                  state_d  = S_MISS;
                  tmr_load = 1'b1;
               end else begin
                  state_d     = S_ACC;
                  mem_read_d  = !new_is_store;
                  mem_write_d = new_is_store;
               end
            end
         end
         S_MISS: begin
            if (tmr_zero) begin
               state_d     = S_ACC;
               mem_read_d  = !is_store_q;
               mem_write_d = is_store_q;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_ACC: state_d = S_RESP;
         S_RESP: begin
            // mem_rdata is valid in the cycle after the access, i.e. now.
            state_d       = S_IDLE;
            resp_valid_d  = 1'b1;
            resp_pc_d     = pc_q;
            resp_data_d   = is_store_q ? '0 : bus.mem_rdata;
            resp_to_lsq_d = src_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         rr_last_q     <= SRC_LSU;
         pc_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         is_store_q    <= 1'b0;
         size_q        <= 1'b0;
         src_q         <= SRC_LSU;
         miss_q        <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_pc_q     <= '0;
         resp_data_q   <= '0;
         resp_to_lsq_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_last_q     <= rr_last_d;
         pc_q          <= pc_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         is_store_q    <= is_store_d;
         size_q        <= size_d;
         src_q         <= src_d;
         miss_q        <= miss_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         resp_valid_q  <= resp_valid_d;
         resp_pc_q     <= resp_pc_d;
         resp_data_q   <= resp_data_d;
         resp_to_lsq_q <= resp_to_lsq_d;
      end
   end

   assign bus.lsu_req_ready  = lsu_rdy;
   assign bus.lsq_req_ready  = lsq_rdy;
   assign bus.mem_pc         = pc_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_store_size = size_q;
   assign bus.mem_from_lsq   = src_q;
   assign bus.mem_cache_miss = miss_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_pc        = resp_pc_q;
   assign bus.resp_data      = resp_data_q;
   assign bus.resp_to_lsq    = resp_to_lsq_q;
   assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Bench for dmem_port_ctrl: directed vector table, corner sequences, and random traffic
// checked against a transaction-level port model.
module tb_dmem_port_ctrl;

   localparam int ML = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic mem_clr;
   always #5 clk = ~clk;

   dmem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_port_ctrl #(.MISS_LATENCY(ML), .ADDR_W(32), .DATA_W(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // dataMemory stand-in: write on access, read data returned one cycle later.
   logic [31:0] dmem [0:63];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
         bus.mem_rdata <= 32'h0;
      end else begin
         if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         bus.mem_rdata <= bus.mem_read ? dmem[bus.mem_addr[7:2]] : 32'h0;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_pc         = 32'h0;
      bus.lsu_addr       = 32'h0;
      bus.lsq_req_valid  = 1'b0;
      bus.lsq_pc         = 32'h0;
      bus.lsq_addr       = 32'h0;
      bus.lsq_wdata      = 32'h0;
      bus.lsq_is_store   = 1'b0;
      bus.lsq_store_size = 1'b0;
      bus.cache_miss     = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   typedef struct {
      logic        is_lsq;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        is_store;
      logic        size;
      logic        miss;
      int          lat;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input int idx, input vec_t v);
      int   w, k, busy_cnt, acc_k;
      logic got, acc_seen;
      logic acc_rd, acc_wr, acc_miss, acc_src, acc_size;
      logic [31:0] acc_addr, r_pc, r_data;
      logic r_lsq;
      if (v.is_lsq) begin
         bus.lsq_req_valid  = 1'b1;
         bus.lsq_pc         = v.pc;
         bus.lsq_addr       = v.addr;
         bus.lsq_wdata      = v.wdata;
         bus.lsq_is_store   = v.is_store;
         bus.lsq_store_size = v.size;
      end else begin
         bus.lsu_req_valid = 1'b1;
         bus.lsu_pc        = v.pc;
         bus.lsu_addr      = v.addr;
      end
      bus.cache_miss = v.miss;
      #1;
      w = 0;
      while (!(bus.lsu_req_ready || bus.lsq_req_ready) && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) begin
         chk($sformatf("vec%0d_handshake_timeout", idx), 32'h0, 32'h1);
         clear_inputs();
         return;
      end
      step();
      bus.lsu_req_valid = 1'b0;
      bus.lsq_req_valid = 1'b0;
      bus.cache_miss    = 1'($urandom_range(0, 1));
      k = 1; got = 1'b0; acc_seen = 1'b0; busy_cnt = 0; acc_k = 0;
      acc_rd = 0; acc_wr = 0; acc_miss = 0; acc_src = 0; acc_size = 0; acc_addr = 0;
      r_pc = 0; r_data = 0; r_lsq = 0;
      while (k <= 20 && !got) begin
         if (bus.busy) busy_cnt++;
         if ((bus.mem_read || bus.mem_write) && !acc_seen) begin
            acc_seen = 1'b1;
            acc_k    = k;
            acc_rd   = bus.mem_read;
            acc_wr   = bus.mem_write;
            acc_addr = bus.mem_addr;
            acc_miss = bus.mem_cache_miss;
            acc_src  = bus.mem_from_lsq;
            acc_size = bus.mem_store_size;
         end
         if (bus.resp_valid) begin
            got    = 1'b1;
            r_pc   = bus.resp_pc;
            r_data = bus.resp_data;
            r_lsq  = bus.resp_to_lsq;
         end else begin
            step();
            k++;
         end
      end
      chk($sformatf("vec%0d_latency", idx), 32'(k), 32'(v.lat));
      chk($sformatf("vec%0d_resp_pc", idx), r_pc, v.pc);
      chk($sformatf("vec%0d_resp_data", idx), r_data, v.rdata);
      chk($sformatf("vec%0d_resp_to_lsq", idx), 32'(r_lsq), 32'(v.is_lsq));
      chk($sformatf("vec%0d_acc_cycle", idx), 32'(acc_k), 32'(v.lat - 2));
      chk($sformatf("vec%0d_mem_read", idx), 32'(acc_rd), 32'(!v.is_store));
      chk($sformatf("vec%0d_mem_write", idx), 32'(acc_wr), 32'(v.is_store));
      chk($sformatf("vec%0d_mem_addr", idx), acc_addr, v.addr);
      chk($sformatf("vec%0d_mem_cache_miss", idx), 32'(acc_miss), 32'(v.miss));
      chk($sformatf("vec%0d_mem_from_lsq", idx), 32'(acc_src), 32'(v.is_lsq));
      chk($sformatf("vec%0d_mem_store_size", idx), 32'(acc_size), 32'(v.size));
      chk($sformatf("vec%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.lat - 1));
      step();
      chk($sformatf("vec%0d_resp_pulse_end", idx), 32'(bus.resp_valid), 32'h0);
   endtask

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic [31:0] data;
      logic        to_lsq;
   } exp_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        exp_q[$];
      logic [31:0] rmem [32];
      int          g, w, cyc, next_free, lat;
      logic        rr, gl, gq, any_resp, miss;
      logic [31:0] pc, addr, data;

      mem_clr = 1'b1;
      do_reset();
      rstn = 1'b0;
      mem_clr = 1'b0;
      step();
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("reset_mem_read", 32'(bus.mem_read), 32'h0);
      chk("reset_mem_write", 32'(bus.mem_write), 32'h0);
      chk("reset_mem_addr", bus.mem_addr, 32'h0);
      chk("reset_resp_pc", bus.resp_pc, 32'h0);
      rstn = 1'b1;
      step();

      //            lsq   pc      addr    wdata         st    sz    miss  lat  rdata
      vecs[0] = '{1'b1, 32'h10, 32'h04, 32'h23,       1'b1, 1'b0, 1'b0, 3,      32'h0};
      vecs[1] = '{1'b0, 32'h18, 32'h04, 32'h0,        1'b0, 1'b0, 1'b0, 3,      32'h23};
      vecs[2] = '{1'b0, 32'h1C, 32'h08, 32'h0,        1'b0, 1'b0, 1'b1, 3 + ML, 32'h0};
      vecs[3] = '{1'b1, 32'h20, 32'h04, 32'h0,        1'b0, 1'b0, 1'b1, 3 + ML, 32'h23};
      vecs[4] = '{1'b1, 32'h24, 32'h08, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 3 + ML, 32'h0};
      vecs[5] = '{1'b0, 32'h28, 32'h08, 32'h0,        1'b0, 1'b0, 1'b0, 3,      32'hDEADBEEF};
      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Both requesters held valid from reset: strict alternation starting with LSQ.
      do_reset();
      bus.lsu_req_valid = 1'b1; bus.lsu_pc = 32'h100; bus.lsu_addr = 32'h40;
      bus.lsq_req_valid = 1'b1; bus.lsq_pc = 32'h200; bus.lsq_addr = 32'h44;
      #1;
      g = 0; w = 0;
      while (g < 4 && w < 40) begin
         chk("rr_one_ready", 32'(bus.lsu_req_ready && bus.lsq_req_ready), 32'h0);
         if (bus.lsu_req_ready || bus.lsq_req_ready) begin
            chk($sformatf("rr_grant%0d_lsq", g), 32'(bus.lsq_req_ready), 32'((g % 2) == 0));
            g++;
         end
         step();
         w++;
      end
      if (g < 4) chk("rr_grant_timeout", 32'(g), 32'h4);
      clear_inputs();
      for (int i = 0; i < 6; i++) step();

      // Reset while the miss penalty is running drops the op silently.
      bus.lsu_req_valid = 1'b1; bus.lsu_pc = 32'h300; bus.lsu_addr = 32'h0C;
      bus.cache_miss = 1'b1;
      #1;
      chk("rstmiss_ready", 32'(bus.lsu_req_ready), 32'h1);
      step();
      clear_inputs();
      step();
      chk("rstmiss_busy_before", 32'(bus.busy), 32'h1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("rstmiss_busy_after", 32'(bus.busy), 32'h0);
      any_resp = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.resp_valid || bus.mem_read) any_resp = 1'b1;
         step();
      end
      chk("rstmiss_no_resp", 32'(any_resp), 32'h0);

      // Requester waits through ACCESS/RESP; payload taken only at its own handshake.
      do_reset();
      bus.lsq_req_valid = 1'b1; bus.lsq_pc = 32'h400; bus.lsq_addr = 32'h10;
      bus.lsq_wdata = 32'h55; bus.lsq_is_store = 1'b1;
      #1;
      chk("hold_first_ready", 32'(bus.lsq_req_ready), 32'h1);
      step();
      bus.lsq_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b1; bus.lsu_pc = 32'hAA; bus.lsu_addr = 32'h10;
      #1;
      chk("hold_ready_in_access", 32'(bus.lsu_req_ready), 32'h0);
      step();
      chk("hold_ready_in_resp", 32'(bus.lsu_req_ready), 32'h0);
      bus.lsu_pc = 32'hAB;
      step();
      chk("hold_first_resp_valid", 32'(bus.resp_valid), 32'h1);
      chk("hold_first_resp_pc", bus.resp_pc, 32'h400);
      chk("hold_ready_in_idle", 32'(bus.lsu_req_ready), 32'h1);
      step();
      bus.lsu_req_valid = 1'b0;
      step();
      step();
      chk("hold_second_resp_valid", 32'(bus.resp_valid), 32'h1);
      chk("hold_second_resp_pc", bus.resp_pc, 32'hAB);
      chk("hold_second_resp_data", bus.resp_data, 32'h55);

      // Random traffic in an untouched address region against a transaction-level model.
      do_reset();
      for (int i = 0; i < 32; i++) rmem[i] = 32'h0;
      cyc = 0; next_free = 0; rr = 1'b0; gl = 1'b0; gq = 1'b0;
      for (int t = 0; t < 700; t++) begin
         if (gl) bus.lsu_req_valid = 1'b0;
         if (gq) bus.lsq_req_valid = 1'b0;
         if (t < 600) begin
            if (!bus.lsu_req_valid && $urandom_range(0, 1) == 1) begin
               bus.lsu_req_valid = 1'b1;
               bus.lsu_pc        = $urandom;
               bus.lsu_addr      = 32'h80 + 32'($urandom_range(0, 31) << 2);
            end
            if (!bus.lsq_req_valid && $urandom_range(0, 1) == 1) begin
               bus.lsq_req_valid  = 1'b1;
               bus.lsq_pc         = $urandom;
               bus.lsq_addr       = 32'h80 + 32'($urandom_range(0, 31) << 2);
               bus.lsq_wdata      = $urandom;
               bus.lsq_is_store   = 1'($urandom_range(0, 1));
               bus.lsq_store_size = 1'($urandom_range(0, 1));
            end
         end
         bus.cache_miss = ($urandom_range(0, 3) == 0);
         #1;
         gl = (cyc >= next_free) && bus.lsu_req_valid && (!bus.lsq_req_valid || rr == 1'b1);
         gq = (cyc >= next_free) && bus.lsq_req_valid && (!bus.lsu_req_valid || rr == 1'b0);
         chk("rand_lsu_ready", 32'(bus.lsu_req_ready), 32'(gl));
         chk("rand_lsq_ready", 32'(bus.lsq_req_ready), 32'(gq));
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            chk("rand_resp_valid", 32'(bus.resp_valid), 32'h1);
            chk("rand_resp_pc", bus.resp_pc, exp_q[0].pc);
            chk("rand_resp_data", bus.resp_data, exp_q[0].data);
            chk("rand_resp_to_lsq", 32'(bus.resp_to_lsq), 32'(exp_q[0].to_lsq));
            void'(exp_q.pop_front());
         end else begin
            chk("rand_resp_idle", 32'(bus.resp_valid), 32'h0);
         end
         if (gl || gq) begin
            miss = bus.cache_miss;
            lat  = 3 + (miss ? ML : 0);
            pc   = gq ? bus.lsq_pc : bus.lsu_pc;
            addr = gq ? bus.lsq_addr : bus.lsu_addr;
            if (gq && bus.lsq_is_store) begin
               data = 32'h0;
               rmem[addr[6:2]] = bus.lsq_wdata;
            end else begin
               data = rmem[addr[6:2]];
            end
            exp_q.push_back('{cyc + lat, pc, data, gq});
            next_free = cyc + lat;
            rr = gq;
         end
         step();
         cyc++;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
